// File: rtl/dso_cmd_pkg.sv
// Shared definitions for the DSO command host.
// Contents:
//   - opcode constants for the DSO digital core command set
//   - the acknowledge byte returned by the core for accepted commands
//   - the state encoding of the uart_cmd_host sequencer
package dso_cmd_pkg;

  localparam logic [7:0] OP_DUMP_CH  = 8'h01;
  localparam logic [7:0] OP_CFG_GAIN = 8'h02;
  localparam logic [7:0] OP_TRIG_LVL = 8'h03;
  localparam logic [7:0] OP_TRIG_POS = 8'h04;
  localparam logic [7:0] OP_SET_DEC  = 8'h05;
  localparam logic [7:0] OP_TRIG_CFG = 8'h06;
  localparam logic [7:0] OP_TRIG_RD  = 8'h07;
  localparam logic [7:0] OP_EEP_WRT  = 8'h08;
  localparam logic [7:0] OP_EEP_RD   = 8'h09;

  localparam logic [7:0] DSO_ACK = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TXW,
    ST_RXW,
    ST_CLR,
    ST_DONE
  } host_state_e;

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   sig_i  - level input (synchronous to clk_i)
//   rise_o - high in a cycle where sig_i is high and was low in the previous cycle
module edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command sequencer for a UART-attached DSO digital core.
// Sends a CMD_BYTES-long command (most significant byte first), then
// collects resp_cnt_i response bytes, optionally checking the first one
// against ACK_BYTE, with a per-byte timeout.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   cmd_i, resp_cnt_i,
//   chk_ack_i, start_i     - command request (sampled only when idle)
//   busy_o, done_o         - sequencer status; done_o pulses once per command
//   resp_vld_o, resp_data_o- one pulse per received response byte
//   nak_o, tmo_o           - sticky error flags, cleared by the next start
//   tx_data_o, trmt_o,
//   tx_done_i              - UART transmit side
//   rx_data_i, rdy_i,
//   clr_rdy_o              - UART receive side
module uart_cmd_host
  import dso_cmd_pkg::*;
#(
  parameter int unsigned CMD_BYTES  = 3,
  parameter int unsigned RESP_CNT_W = 10,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter logic [7:0]  ACK_BYTE   = DSO_ACK
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [8*CMD_BYTES-1:0]  cmd_i,
  input  logic [RESP_CNT_W-1:0]   resp_cnt_i,
  input  logic                    chk_ack_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    resp_vld_o,
  output logic [7:0]              resp_data_o,
  output logic                    nak_o,
  output logic                    tmo_o,
  output logic [7:0]              tx_data_o,
  output logic                    trmt_o,
  input  logic                    tx_done_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rdy_i,
  output logic                    clr_rdy_o
);

  localparam int unsigned IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  host_state_e             state_q, state_d;
  logic [8*CMD_BYTES-1:0]  cmd_q, cmd_d;
  logic [RESP_CNT_W-1:0]   cnt_q, cnt_d;
  logic [RESP_CNT_W-1:0]   rem_q, rem_d;
  logic                    chk_q, chk_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    trmt_q, trmt_d;
  logic [7:0]              resp_data_q, resp_data_d;
  logic                    resp_vld_q, resp_vld_d;
  logic                    clr_rdy_q, clr_rdy_d;
  logic                    nak_q, nak_d;
  logic                    tmo_q, tmo_d;
  logic                    tx_rise;

  // tx_done may still be high from the previous byte; only a fresh rise
  // marks completion of the byte just handed over.
  edge_det u_tx_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (tx_done_i),
    .rise_o (tx_rise)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_data_d = resp_data_q;
    resp_vld_d  = 1'b0;
    clr_rdy_d   = 1'b0;
    nak_d       = nak_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cmd_d   = cmd_i;
          cnt_d   = resp_cnt_i;
          chk_d   = chk_ack_i;
          nak_d   = 1'b0;
          tmo_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The command is shifted so the next byte to send is always on top.
        tx_data_d = cmd_q[8*CMD_BYTES-1 -: 8];
        cmd_d     = cmd_q << 8;
        trmt_d    = 1'b1;
        state_d   = ST_TXW;
      end
      ST_TXW: begin
        if (tx_rise) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = cnt_q;
            tmr_d   = '0;
            state_d = ST_RXW;
          end
        end
      end
      ST_RXW: begin
        // A byte arriving in the expiry cycle still wins over the timeout.
        if (rdy_i) begin
          resp_data_d = rx_data_i;
          resp_vld_d  = 1'b1;
          clr_rdy_d   = 1'b1;
          if (chk_q && (rem_q == cnt_q) && (rx_data_i != ACK_BYTE)) begin
            nak_d = 1'b1;
          end
          rem_d   = rem_q - 1'b1;
          tmr_d   = '0;
          state_d = ST_CLR;
        end else if (tmr_q == TMR_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_CLR: begin
        // Wait for the UART to drop rdy so one byte is never taken twice;
        // after the final byte there is nothing left to protect.
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (!rdy_i) begin
          state_d = ST_RXW;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      chk_q       <= 1'b0;
      idx_q       <= '0;
      tmr_q       <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_data_q <= '0;
      resp_vld_q  <= 1'b0;
      clr_rdy_q   <= 1'b0;
      nak_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_data_q <= resp_data_d;
      resp_vld_q  <= resp_vld_d;
      clr_rdy_q   <= clr_rdy_d;
      nak_q       <= nak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_TXW) ||
                       (state_q == ST_RXW)  || (state_q == ST_CLR);
  assign done_o      = (state_q == ST_DONE);
  assign resp_vld_o  = resp_vld_q;
  assign resp_data_o = resp_data_q;
  assign nak_o       = nak_q;
  assign tmo_o       = tmo_q;
  assign tx_data_o   = tx_data_q;
  assign trmt_o      = trmt_q;
  assign clr_rdy_o   = clr_rdy_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host with a small UART/DSO model.
module tb_uart_cmd_host;
  import dso_cmd_pkg::*;

  localparam int CB     = 3;
  localparam int CW     = 10;
  localparam int TMO    = 1000;
  localparam int TX_LAT = 4;
  localparam int RX_GAP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*CB-1:0] cmd = '0;
  logic [CW-1:0]   resp_cnt = '0;
  logic            chk_ack = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, resp_vld, nak, tmo, trmt, clr_rdy;
  logic [7:0]      resp_data, tx_data;
  logic            tx_done, rdy;
  logic [7:0]      rx_data;

  always #5 clk = ~clk;

  uart_cmd_host #(
    .CMD_BYTES  (CB),
    .RESP_CNT_W (CW),
    .TIMEOUT    (TMO),
    .ACK_BYTE   (8'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_i       (cmd),
    .resp_cnt_i  (resp_cnt),
    .chk_ack_i   (chk_ack),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .resp_vld_o  (resp_vld),
    .resp_data_o (resp_data),
    .nak_o       (nak),
    .tmo_o       (tmo),
    .tx_data_o   (tx_data),
    .trmt_o      (trmt),
    .tx_done_i   (tx_done),
    .rx_data_i   (rx_data),
    .rdy_i       (rdy),
    .clr_rdy_o   (clr_rdy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART + DSO model: tx_done rises TX_LAT cycles after trmt; response
  // bytes start only after the whole command has been shifted out.
  logic [7:0] rx_mem [0:1023];
  int rx_n = 0;
  int rx_rd, m_tx, tx_tmr, gap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b0;
      rdy     <= 1'b0;
      rx_data <= 8'h00;
      rx_rd   <= 0;
      m_tx    <= 0;
      tx_tmr  <= 0;
      gap     <= RX_GAP;
    end else begin
      if (trmt) begin
        tx_done <= 1'b0;
        tx_tmr  <= TX_LAT;
        m_tx    <= m_tx + 1;
      end else if (tx_tmr != 0) begin
        tx_tmr <= tx_tmr - 1;
        if (tx_tmr == 1) tx_done <= 1'b1;
      end
      if (done) begin
        m_tx  <= 0;
        rx_rd <= 0;
      end
      if (clr_rdy) begin
        rdy <= 1'b0;
      end else if (!rdy && m_tx == CB && tx_done && rx_rd < rx_n) begin
        if (gap == 0) begin
          rx_data <= rx_mem[rx_rd];
          rdy     <= 1'b1;
          rx_rd   <= rx_rd + 1;
          gap     <= RX_GAP;
        end else begin
          gap <= gap - 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-command observations, all gathered on falling edges.
  int n_trmt, n_vld, n_clr, n_done, busy_gap, first_trmt, last_vld_cyc, done_cyc, t0;
  logic [7:0] tx_log [0:7];
  logic [7:0] vld_log [0:1023];
  logic nak_early, tmo_early;

  task automatic clr_stats();
    n_trmt = 0; n_vld = 0; n_clr = 0; n_done = 0; busy_gap = 0;
    first_trmt = -1; last_vld_cyc = -1; done_cyc = -1;
  endtask

  task automatic sample();
    @(negedge clk);
    if (trmt) begin
      if (n_trmt < 8) tx_log[n_trmt] = tx_data;
      if (n_trmt == 0) first_trmt = cyc;
      n_trmt++;
    end
    if (resp_vld) begin
      if (n_vld < 1024) vld_log[n_vld] = resp_data;
      n_vld++;
      last_vld_cyc = cyc;
    end
    if (clr_rdy) n_clr++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic send_cmd(input logic [8*CB-1:0] c, input int cnt, input logic ck);
    clr_stats();
    cmd = c;
    resp_cnt = CW'(cnt);
    chk_ack = ck;
    start = 1'b1;
    t0 = cyc;
    sample();
    start = 1'b0;
    nak_early = nak;
    tmo_early = tmo;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (n_done == 0 && i < limit) begin
      if (!busy) busy_gap++;
      sample();
      i++;
    end
    repeat (3) sample();
  endtask

  task automatic check_quiet(input string tag);
    check_val(tag, int'({busy, done, resp_vld, resp_data, nak, tmo, tx_data, trmt, clr_rdy}), 0);
  endtask

  logic [7:0] eep_addr, eep_data;
  int data_err;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("in_reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset_outputs");

    // 1: CFG_GAIN with ack check, DSO answers A5
    rx_mem[0] = 8'hA5; rx_n = 1;
    send_cmd({OP_CFG_GAIN, 8'h1C, 8'h00}, 1, 1'b1);
    wait_done(300);
    check_val("t1_trmt_cnt", n_trmt, 3);
    check_val("t1_tx0", int'(tx_log[0]), 'h02);
    check_val("t1_tx1", int'(tx_log[1]), 'h1C);
    check_val("t1_tx2", int'(tx_log[2]), 'h00);
    check_val("t1_start_to_trmt", first_trmt - t0, 2);
    check_val("t1_vld_cnt", n_vld, 1);
    check_val("t1_resp", int'(vld_log[0]), 'hA5);
    check_val("t1_nak", int'(nak), 0);
    check_val("t1_tmo", int'(tmo), 0);
    check_val("t1_done_cnt", n_done, 1);
    check_val("t1_vld_to_done", done_cyc - last_vld_cyc, 1);
    check_val("t1_busy_gap", busy_gap, 0);

    // 2: EEP_WRT then EEP_RD; the model stores what it actually received
    rx_mem[0] = 8'hA5; rx_n = 1;
    send_cmd({OP_EEP_WRT, 8'h2A, 8'h99}, 1, 1'b1);
    wait_done(300);
    check_val("t2_wr_done", n_done, 1);
    check_val("t2_wr_nak", int'(nak), 0);
    eep_addr = tx_log[1];
    eep_data = tx_log[2];
    rx_mem[0] = (eep_addr == 8'h2A) ? eep_data : 8'h00;
    send_cmd({OP_EEP_RD, 8'h2A, 8'h00}, 1, 1'b0);
    wait_done(300);
    check_val("t2_rd_op", int'(tx_log[0]), 'h09);
    check_val("t2_rd_vld_cnt", n_vld, 1);
    check_val("t2_rd_data", int'(vld_log[0]), 'h99);
    check_val("t2_rd_nak", int'(nak), 0);

    // 3: DUMP_CH with a 512-byte response
    for (int i = 0; i < 512; i++) rx_mem[i] = 8'(i) ^ 8'h5C;
    rx_n = 512;
    send_cmd({OP_DUMP_CH, 8'h00, 8'h00}, 512, 1'b0);
    wait_done(20000);
    check_val("t3_vld_cnt", n_vld, 512);
    check_val("t3_clr_cnt", n_clr, 512);
    data_err = 0;
    for (int i = 0; i < 512; i++) if (vld_log[i] !== (8'(i) ^ 8'h5C)) data_err++;
    check_val("t3_data_err", data_err, 0);
    check_val("t3_busy_gap", busy_gap, 0);
    check_val("t3_done_cnt", n_done, 1);
    check_val("t3_vld_to_done", done_cyc - last_vld_cyc, 1);

    // 4: TRIG_LVL answered with 5A -> nak, cleared by the next start
    rx_mem[0] = 8'h5A; rx_n = 1;
    send_cmd({OP_TRIG_LVL, 8'h80, 8'h00}, 1, 1'b1);
    wait_done(300);
    check_val("t4_nak", int'(nak), 1);
    check_val("t4_done_cnt", n_done, 1);
    check_val("t4_resp", int'(vld_log[0]), 'h5A);
    rx_mem[0] = 8'hA5;
    send_cmd({OP_TRIG_POS, 8'h10, 8'h00}, 1, 1'b1);
    check_val("t4_nak_cleared", int'(nak_early), 0);
    wait_done(300);
    check_val("t4_nak_after", int'(nak), 0);

    // 5: 3 bytes expected, only 2 delivered. Timeout after 1000 idle RXW
    // cycles, preceded by 2 CLR cycles after the last resp_vld, so done
    // appears 1002 cycles after the second resp_vld.
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h3C; rx_n = 2;
    send_cmd({OP_SET_DEC, 8'h03, 8'h00}, 3, 1'b1);
    wait_done(3000);
    check_val("t5_tmo", int'(tmo), 1);
    check_val("t5_vld_cnt", n_vld, 2);
    check_val("t5_done_cnt", n_done, 1);
    check_val("t5_vld_to_done", done_cyc - last_vld_cyc, 1002);
    check_val("t5_nak", int'(nak), 0);

    // 6: extra start during TXW, then reset during RXW
    rx_mem[0] = 8'hA5; rx_n = 1;
    send_cmd({OP_TRIG_CFG, 8'h11, 8'h22}, 4, 1'b1);
    for (int i = 0; i < 100 && n_trmt < 1; i++) sample();
    sample();
    cmd = {OP_TRIG_RD, 8'h77, 8'h77};
    start = 1'b1;
    sample();
    start = 1'b0;
    for (int i = 0; i < 300 && n_vld < 1; i++) sample();
    repeat (5) sample();
    check_val("t6_trmt_cnt", n_trmt, 3);
    check_val("t6_tx0", int'(tx_log[0]), 'h06);
    check_val("t6_tx2", int'(tx_log[2]), 'h22);
    check_val("t6_busy_rxw", int'(busy), 1);
    rst_n = 1'b0;
    sample();
    check_quiet("t6_in_reset");
    repeat (2) sample();
    rst_n = 1'b1;
    repeat (20) sample();
    check_quiet("t6_after_reset");
    check_val("t6_no_done", n_done, 0);
    rx_mem[0] = 8'hA5; rx_n = 1;
    send_cmd({OP_TRIG_RD, 8'h00, 8'h00}, 1, 1'b1);
    check_val("t6_tmo_clear", int'(tmo_early), 0);
    wait_done(300);
    check_val("t6_next_op", int'(tx_log[0]), 'h07);
    check_val("t6_next_done", n_done, 1);
    check_val("t6_next_resp", int'(vld_log[0]), 'hA5);
    check_val("t6_next_nak", int'(nak), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
